// File: rtl/multi_mode_conv_path_pkg.sv
// Shared definitions for the multi-mode ternary convolution datapath.
// Holds the command codes, the ternary weight encodings, the FSM state
// encoding, the weight memory latency, and the scale/saturate helper
// used when results leave the accumulators.
package multi_mode_conv_path_pkg;

  // Command codes carried on com_type
  localparam logic [7:0] COM_CONV   = 8'h01;
  localparam logic [7:0] COM_DWCONV = 8'h02;
  localparam logic [7:0] COM_PWCONV = 8'h04;

  // Ternary weight codes; 2'b00 and 2'b10 both mean zero
  localparam logic [1:0] TERN_POS = 2'b01;
  localparam logic [1:0] TERN_NEG = 2'b11;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_WIN = 3'd1;
  localparam logic [2:0] ST_ISSUE    = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_OUTPUT   = 3'd4;

  // Cycles from weight_rd_en to weight_data being valid
  localparam int WEIGHT_LATENCY = 1;

  typedef enum logic [1:0] {
    MODE_CONV,
    MODE_DW,
    MODE_PW
  } mode_e;

  function automatic logic is_legal_com(input logic [7:0] t);
    return (t == COM_CONV) || (t == COM_DWCONV) || (t == COM_PWCONV);
  endfunction

  function automatic mode_e com_to_mode(input logic [7:0] t);
    mode_e m;
    case (t)
      COM_DWCONV: m = MODE_DW;
      COM_PWCONV: m = MODE_PW;
      default:    m = MODE_CONV;
    endcase
    return m;
  endfunction

  // Multiplies an accumulator by a fixed-point scaler, drops the fraction
  // bits with an arithmetic shift (rounds toward minus infinity) and clamps
  // to a signed outWidth range. Operands arrive sign-extended to 64 bits.
  function automatic logic signed [63:0] scale_saturate(
    input logic signed [63:0] acc,
    input logic signed [63:0] scaler,
    input int                 frac,
    input int                 outWidth
  );
    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    prod    = acc * scaler;
    shifted = prod >>> frac;
    maxV    = (64'sd1 <<< (outWidth - 1)) - 64'sd1;
    minV    = -(64'sd1 <<< (outWidth - 1));
    if (shifted > maxV) begin
      return maxV;
    end else if (shifted < minV) begin
      return minV;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/multi_mode_conv_path_ternary_dot_unit.sv
// Combinational ternary dot product over one TN x K x K window.
// Ports:
//   win_data_i    - TN*K*K signed features, channel n occupies taps n*K*K..
//   weight_data_i - matching 2-bit ternary codes
//   centre_only_i - when set only the centre tap of each channel counts
//   lane_sum_o    - per-channel partial sums, TN lanes of ACC_WIDTH
//   total_sum_o   - sum of all lanes
module ternary_dot_unit
  import multi_mode_conv_path_pkg::*;
#(
  parameter int TN            = 4,
  parameter int FEATURE_WIDTH = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int ACC_WIDTH     = 24
) (
  input  logic [TN*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] win_data_i,
  input  logic [TN*KERNEL_SIZE*KERNEL_SIZE*2-1:0]             weight_data_i,
  input  logic                                                centre_only_i,
  output logic [TN*ACC_WIDTH-1:0]                             lane_sum_o,
  output logic signed [ACC_WIDTH-1:0]                         total_sum_o
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;

  logic signed [ACC_WIDTH-1:0] laneAcc [TN];
  logic signed [ACC_WIDTH-1:0] featExt;
  logic [1:0]                  code;

  // Each product is the feature sign-extended to accumulator width and then
  // added, subtracted or dropped; all sums wrap at ACC_WIDTH.
  always_comb begin
    total_sum_o = '0;
    lane_sum_o  = '0;
    featExt     = '0;
    code        = '0;
    for (int n = 0; n < TN; n++) begin
      laneAcc[n] = '0;
      for (int k = 0; k < KK; k++) begin
        featExt = ACC_WIDTH'($signed(win_data_i[(n*KK+k)*FEATURE_WIDTH +: FEATURE_WIDTH]));
        code    = weight_data_i[(n*KK+k)*2 +: 2];
        if (!centre_only_i || (k == KK/2)) begin
          if (code == TERN_POS) begin
            laneAcc[n] = laneAcc[n] + featExt;
          end else if (code == TERN_NEG) begin
            laneAcc[n] = laneAcc[n] - featExt;
          end
        end
      end
      lane_sum_o[n*ACC_WIDTH +: ACC_WIDTH] = laneAcc[n];
      total_sum_o = total_sum_o + laneAcc[n];
    end
  end

endmodule

// File: rtl/multi_mode_conv_path.sv
// Multi-mode ternary convolution datapath (CONV / DWCONV / PWCONV).
// Accumulates one or more input tiles into TM channel accumulators, reading
// one ternary weight word per output channel (or one per tile in DWCONV),
// then scales, saturates and presents TM results.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cfg_valid/com_type/...   - configuration load, accepted only in IDLE
//   busy                     - high whenever not IDLE
//   win_valid/win_ready/win_data - feature window handshake
//   weight_rd_en/weight_addr/weight_data - weight memory, 1-cycle latency
//   scaler_data              - per-channel fixed-point scalers
//   out_valid/out_ready/out_data - result handshake, lane c = channel c
module multi_mode_conv_path
  import multi_mode_conv_path_pkg::*;
#(
  parameter int TN            = 4,
  parameter int TM            = 16,
  parameter int FEATURE_WIDTH = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int SCALER_WIDTH  = 16,
  parameter int SCALER_FRAC   = 8,
  parameter int ACC_WIDTH     = 24
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                cfg_valid,
  input  logic [7:0]                                          com_type,
  input  logic [7:0]                                          cfg_in_tiles,
  input  logic [15:0]                                         cfg_weight_base,
  output logic                                                busy,
  input  logic                                                win_valid,
  output logic                                                win_ready,
  input  logic [TN*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] win_data,
  output logic                                                weight_rd_en,
  output logic [15:0]                                         weight_addr,
  input  logic [TN*KERNEL_SIZE*KERNEL_SIZE*2-1:0]             weight_data,
  input  logic [TM*SCALER_WIDTH-1:0]                          scaler_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [TM*FEATURE_WIDTH-1:0]                         out_data
);

  localparam int KK           = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WIN_W        = TN * KK * FEATURE_WIDTH;
  localparam int CNT_W        = $clog2(TM + 1);
  localparam int DRAIN_CYCLES = WEIGHT_LATENCY + 1;

  logic [2:0]                   state_q, state_d;
  mode_e                        mode_q, mode_d;
  logic [7:0]                   tiles_q, tiles_d;
  logic [15:0]                  base_q, base_d;
  logic [7:0]                   tileIdx_q, tileIdx_d;
  logic [CNT_W-1:0]             issueCnt_q, issueCnt_d;
  logic [1:0]                   drainCnt_q, drainCnt_d;
  logic [WIN_W-1:0]             win_q, win_d;
  logic                         pendValid_q, pendValid_d;
  logic [CNT_W-1:0]             pendChan_q, pendChan_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [TM];
  logic signed [ACC_WIDTH-1:0]  acc_d [TM];
  logic                         outValid_q, outValid_d;
  logic [TM*FEATURE_WIDTH-1:0]  outData_q, outData_d;

  logic [TN*ACC_WIDTH-1:0]      laneSum;
  logic signed [ACC_WIDTH-1:0]  totalSum;
  logic [15:0]                  issueAddr;

  ternary_dot_unit #(
    .TN            (TN),
    .FEATURE_WIDTH (FEATURE_WIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_dot (
    .win_data_i    (win_q),
    .weight_data_i (weight_data),
    .centre_only_i (mode_q == MODE_PW),
    .lane_sum_o    (laneSum),
    .total_sum_o   (totalSum)
  );

  // Weight address: one word per output channel per tile in CONV/PWCONV,
  // one word per tile in DWCONV. Driven to zero outside ISSUE.
  always_comb begin
    if (mode_q == MODE_DW) begin
      issueAddr = base_q + {8'd0, tileIdx_q};
    end else begin
      issueAddr = base_q + 16'(tileIdx_q) * 16'(TM) + 16'(issueCnt_q);
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign win_ready    = (state_q == ST_WAIT_WIN);
  assign weight_rd_en = (state_q == ST_ISSUE);
  assign weight_addr  = (state_q == ST_ISSUE) ? issueAddr : 16'd0;
  assign out_valid    = outValid_q;
  assign out_data     = outData_q;

  // Next-state logic. The pending tag follows each read strobe by one cycle,
  // so the returning weight word is folded into its accumulator at the edge
  // that ends the cycle in which it is valid; DRAIN covers the last one.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tiles_d     = tiles_q;
    base_d      = base_q;
    tileIdx_d   = tileIdx_q;
    issueCnt_d  = issueCnt_q;
    drainCnt_d  = drainCnt_q;
    win_d       = win_q;
    pendValid_d = 1'b0;
    pendChan_d  = pendChan_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    for (int c = 0; c < TM; c++) begin
      acc_d[c] = acc_q[c];
    end

    if (pendValid_q) begin
      if (mode_q == MODE_DW) begin
        for (int n = 0; n < TN; n++) begin
          acc_d[n] = acc_q[n] + $signed(laneSum[n*ACC_WIDTH +: ACC_WIDTH]);
        end
      end else begin
        for (int c = 0; c < TM; c++) begin
          if (pendChan_q == CNT_W'(c)) begin
            acc_d[c] = acc_q[c] + totalSum;
          end
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && is_legal_com(com_type)) begin
          mode_d     = com_to_mode(com_type);
          tiles_d    = (cfg_in_tiles == 8'd0) ? 8'd1 : cfg_in_tiles;
          base_d     = cfg_weight_base;
          tileIdx_d  = '0;
          issueCnt_d = '0;
          for (int c = 0; c < TM; c++) begin
            acc_d[c] = '0;
          end
          state_d    = ST_WAIT_WIN;
        end
      end
      ST_WAIT_WIN: begin
        if (win_valid) begin
          win_d      = win_data;
          issueCnt_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pendValid_d = 1'b1;
        pendChan_d  = issueCnt_q;
        if ((mode_q == MODE_DW) || (issueCnt_q == CNT_W'(TM - 1))) begin
          issueCnt_d = '0;
          drainCnt_d = '0;
          state_d    = ST_DRAIN;
        end else begin
          issueCnt_d = issueCnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == 2'(DRAIN_CYCLES - 1)) begin
          tileIdx_d = tileIdx_q + 8'd1;
          if (({1'b0, tileIdx_q} + 9'd1) < {1'b0, tiles_q}) begin
            state_d = ST_WAIT_WIN;
          end else begin
            for (int c = 0; c < TM; c++) begin
              outData_d[c*FEATURE_WIDTH +: FEATURE_WIDTH] = FEATURE_WIDTH'(scale_saturate(
                64'(acc_q[c]),
                64'($signed(scaler_data[c*SCALER_WIDTH +: SCALER_WIDTH])),
                SCALER_FRAC, FEATURE_WIDTH));
            end
            outValid_d = 1'b1;
            state_d    = ST_OUTPUT;
          end
        end else begin
          drainCnt_d = drainCnt_q + 2'd1;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset also drops any weight still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONV;
      tiles_q     <= 8'd1;
      base_q      <= '0;
      tileIdx_q   <= '0;
      issueCnt_q  <= '0;
      drainCnt_q  <= '0;
      win_q       <= '0;
      pendValid_q <= 1'b0;
      pendChan_q  <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      for (int c = 0; c < TM; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tiles_q     <= tiles_d;
      base_q      <= base_d;
      tileIdx_q   <= tileIdx_d;
      issueCnt_q  <= issueCnt_d;
      drainCnt_q  <= drainCnt_d;
      win_q       <= win_d;
      pendValid_q <= pendValid_d;
      pendChan_q  <= pendChan_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      for (int c = 0; c < TM; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_conv_path.sv
// Self-checking bench for multi_mode_conv_path.
// A table of directed vectors drives whole operations and compares every
// output lane plus the weight address stream; hand-written sequences cover
// output back-pressure, mid-operation reset and illegal commands.
module tb_multi_mode_conv_path;

  localparam int TN  = 4;
  localparam int TM  = 16;
  localparam int FW  = 16;
  localparam int K   = 3;
  localparam int KK  = K * K;
  localparam int SW  = 16;
  localparam int NV  = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_valid;
  logic [7:0]            com_type;
  logic [7:0]            cfg_in_tiles;
  logic [15:0]           cfg_weight_base;
  logic                  busy;
  logic                  win_valid;
  logic                  win_ready;
  logic [TN*KK*FW-1:0]   win_data;
  logic                  weight_rd_en;
  logic [15:0]           weight_addr;
  logic [TN*KK*2-1:0]    weight_data;
  logic [TM*SW-1:0]      scaler_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [TM*FW-1:0]      out_data;

  logic [TN*KK*2-1:0]    wFill;
  int                    addrQ[$];
  int                    compared = 0;
  int                    mismatched = 0;

  typedef struct {
    logic [7:0]  comType;
    logic [7:0]  tiles;
    logic [15:0] base;
    bit          perChan;
    int          featOther;
    int          featCentre;
    logic [1:0]  wCode;
    int          scaler;
    int          expLow;
    int          expHigh;
    int          addrCount;
  } vec_t;

  vec_t vecs [NV];

  multi_mode_conv_path #(
    .TN(TN), .TM(TM), .FEATURE_WIDTH(FW), .KERNEL_SIZE(K),
    .SCALER_WIDTH(SW), .SCALER_FRAC(8), .ACC_WIDTH(24)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .com_type(com_type),
    .cfg_in_tiles(cfg_in_tiles), .cfg_weight_base(cfg_weight_base),
    .busy(busy), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .weight_rd_en(weight_rd_en),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .scaler_data(scaler_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Weight memory model: the word requested on a strobe is valid next cycle
  always @(posedge clk) begin
    if (weight_rd_en) begin
      addrQ.push_back(int'(weight_addr));
      weight_data <= wFill;
    end else begin
      weight_data <= '0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int laneVal(input int c);
    return int'($signed(out_data[c*FW +: FW]));
  endfunction

  // Loads a vector, streams windows until the result appears (bounded)
  task automatic applyStimulus(input int idx, output bit ok);
    vec_t v;
    int   val;
    v = vecs[idx];
    @(negedge clk);
    for (int n = 0; n < TN; n++) begin
      for (int k = 0; k < KK; k++) begin
        val = v.perChan ? (n + 1) : ((k == KK/2) ? v.featCentre : v.featOther);
        win_data[(n*KK+k)*FW +: FW] = 16'(val);
      end
    end
    for (int e = 0; e < TN*KK; e++) wFill[e*2 +: 2] = v.wCode;
    for (int c = 0; c < TM; c++) scaler_data[c*SW +: SW] = 16'(v.scaler);
    com_type        = v.comType;
    cfg_in_tiles    = v.tiles;
    cfg_weight_base = v.base;
    cfg_valid       = 1'b1;
    addrQ.delete();
    @(negedge clk);
    cfg_valid = 1'b0;
    win_valid = 1'b1;
    ok = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    win_valid = 1'b0;
    if (!ok) checkOutput($sformatf("v%0d_timeout", idx), 0, 1);
  endtask

  task automatic checkLanes(input int idx);
    vec_t v;
    int   exp;
    bit   contiguous;
    v = vecs[idx];
    for (int c = 0; c < TM; c++) begin
      if (c < TN) exp = v.perChan ? v.expLow * (c + 1) : v.expLow;
      else        exp = v.expHigh;
      checkOutput($sformatf("v%0d_lane%0d", idx, c), laneVal(c), exp);
    end
    checkOutput($sformatf("v%0d_addr_count", idx), addrQ.size(), v.addrCount);
    contiguous = 1'b1;
    foreach (addrQ[i]) if (addrQ[i] != int'(v.base) + i) contiguous = 1'b0;
    checkOutput($sformatf("v%0d_addr_seq", idx), int'(contiguous), 1);
  endtask

  task automatic finishOutput(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_busy_after"}, int'(busy), 0);
    checkOutput({name, "_valid_after"}, int'(out_valid), 0);
  endtask

  initial begin
    bit ok;

    //                comType tiles base   pc  other  centre wCode  scaler expLow  expHigh  addrs
    vecs[0]  = '{8'h01, 8'd1, 16'd0,   1'b0, 1,     1,     2'b01, 256,   36,     36,      16};
    vecs[1]  = '{8'h01, 8'd3, 16'd100, 1'b0, 2,     2,     2'b11, 128,   -108,   -108,    48};
    vecs[2]  = '{8'h02, 8'd1, 16'd0,   1'b1, 0,     0,     2'b01, 256,   9,      0,       1};
    vecs[3]  = '{8'h04, 8'd1, 16'd0,   1'b0, 1000,  5,     2'b01, 256,   20,     20,      16};
    vecs[4]  = '{8'h04, 8'd1, 16'd0,   1'b0, 1000,  15000, 2'b01, 256,   32767,  32767,   16};
    vecs[5]  = '{8'h04, 8'd1, 16'd0,   1'b0, 1000,  15000, 2'b11, 256,   -32768, -32768,  16};
    vecs[6]  = '{8'h01, 8'd0, 16'd7,   1'b0, 1,     1,     2'b01, 256,   36,     36,      16};
    vecs[7]  = '{8'h01, 8'd8, 16'd0,   1'b0, 32767, 32767, 2'b01, 256,   -32768, -32768,  128};
    vecs[8]  = '{8'h01, 8'd1, 16'd0,   1'b0, 5,     5,     2'b10, 256,   0,      0,       16};
    vecs[9]  = '{8'h02, 8'd2, 16'd50,  1'b1, 0,     0,     2'b11, 384,   -27,    0,       2};
    vecs[10] = '{8'h01, 8'd1, 16'd0,   1'b0, 1,     1,     2'b11, 100,   -15,    -15,     16};

    rst = 1'b1; cfg_valid = 1'b0; com_type = '0; cfg_in_tiles = '0;
    cfg_weight_base = '0; win_valid = 1'b0; win_data = '0; out_ready = 1'b0;
    scaler_data = '0; wFill = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_win_ready", int'(win_ready), 0);
    checkOutput("rst_rd_en", int'(weight_rd_en), 0);
    checkOutput("rst_addr", int'(weight_addr), 0);
    checkOutput("rst_out_data_nonzero", int'(out_data != '0), 0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      applyStimulus(i, ok);
      if (ok) begin
        checkLanes(i);
        finishOutput($sformatf("v%0d", i));
      end
    end

    // Illegal commands leave the block idle
    @(negedge clk); com_type = 8'h03; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0;
    checkOutput("illegal_03_busy", int'(busy), 0);
    com_type = 8'h00; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0;
    checkOutput("illegal_00_busy", int'(busy), 0);
    checkOutput("illegal_00_win_ready", int'(win_ready), 0);

    // Back-pressure: result holds while cfg_valid and win_valid toggle
    applyStimulus(0, ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        cfg_valid = (i % 2 == 0);
        win_valid = (i % 3 == 0);
        com_type  = 8'h02;
        @(negedge clk);
        checkOutput($sformatf("hold%0d_valid", i), int'(out_valid), 1);
        checkOutput($sformatf("hold%0d_win_ready", i), int'(win_ready), 0);
        checkOutput($sformatf("hold%0d_lane0", i), laneVal(0), 36);
        checkOutput($sformatf("hold%0d_lane15", i), laneVal(15), 36);
      end
      win_valid = 1'b0;
      cfg_valid = 1'b1;
      com_type  = 8'h01;
      out_ready = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      out_ready = 1'b0;
      checkOutput("hs_cfg_busy", int'(busy), 0);
      checkOutput("hs_cfg_valid", int'(out_valid), 0);
      @(negedge clk);
      checkOutput("hs_cfg_busy_later", int'(busy), 0);
    end

    // Reset in the middle of ISSUE
    wFill = {(TN*KK){2'b01}};
    com_type = 8'h01; cfg_in_tiles = 8'd2; cfg_weight_base = 16'd0;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    win_valid = 1'b1;
    ok = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (weight_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    win_valid = 1'b0;
    checkOutput("midrst_reached_issue", int'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_rd_en", int'(weight_rd_en), 0);
    checkOutput("midrst_addr", int'(weight_addr), 0);
    checkOutput("midrst_win_ready", int'(win_ready), 0);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    rst = 1'b0;

    // Recovery after reset
    applyStimulus(0, ok);
    if (ok) begin
      checkLanes(0);
      finishOutput("recover");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
